ex_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit. It sits beside the single-cycle EX ALU and serves MULT/MULTU/DIV/DIVU. It accepts one operation through a valid/ready handshake and computes it radix-2, one bit per cycle. It returns a HI/LO result pair under a valid/ready handshake. The ID stage stalls on start_ready low; the WB/HI-LO write path consumes the result.

---
 rtl/ex_muldiv_unit_pkg.sv | 28 ++
 rtl/ex_muldiv_unit_negate.sv | 20 ++
 rtl/ex_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// ============================================================================
// Module   : ex_muldiv_unit_pkg
// Brief    : Op and state encodings shared by the iterative mul/div unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_muldiv_unit_pkg;

  localparam int MD_OP_BUS = 2;

  typedef enum logic [MD_OP_BUS-1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_unit_negate.sv
// ============================================================================
// Module   : md_negate
// Brief    : Conditional two's-complement negation, width-generic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [MD_OP_BUS-1:0] op,
  input  logic [WIDTH-1:0]     operand_1,
  input  logic [WIDTH-1:0]     operand_2,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [WIDTH-1:0]     result_hi,
  output logic [WIDTH-1:0]     result_lo,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  md_op_e             w_op;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_sign1, w_sign2;
  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_op        = md_op_e'(op);
  assign w_is_div    = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_is_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_sign1     = w_is_signed & operand_1[WIDTH-1];
  assign w_sign2     = w_is_signed & operand_2[WIDTH-1];

  // Most-negative input maps onto itself, which reads correctly as unsigned 2^(W-1).
  md_negate #(.WIDTH(WIDTH)) u_abs1 (.neg_i(w_sign1), .a_i(operand_1), .y_o(w_abs1));
  md_negate #(.WIDTH(WIDTH)) u_abs2 (.neg_i(w_sign2), .a_i(operand_2), .y_o(w_abs2));

  md_negate #(.WIDTH(2*WIDTH)) u_prod (.neg_i(neg_quo_q), .a_i(acc_q), .y_o(w_prod_fix));
  md_negate #(.WIDTH(WIDTH)) u_quo (.neg_i(neg_quo_q), .a_i(acc_q[WIDTH-1:0]), .y_o(w_quo_fix));
  md_negate #(.WIDTH(WIDTH)) u_rem (.neg_i(neg_rem_q), .a_i(acc_q[2*WIDTH-1:WIDTH]), .y_o(w_rem_fix));

  // Multiply: acc = {product-high, multiplier}; the carry lands in the shifted-down top bit.
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
  // Divide: acc = {rem, quo}; borrow out of the trial subtract means rem_sh < divisor.
  assign w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_rem_sub = w_rem_sh - {1'b0, b_q};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    if (flush) begin
      state_d = MD_IDLE;
      dbz_d   = 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_valid) begin
            op_d  = w_op;
            dbz_d = 1'b0;
            if (w_is_div && (operand_2 == {WIDTH{1'b0}})) begin
              hi_d    = operand_1;
              lo_d    = {WIDTH{1'b1}};
              dbz_d   = 1'b1;
              state_d = MD_DONE;
            end else begin
              neg_quo_d = w_sign1 ^ w_sign2;
              neg_rem_d = w_sign1;
              cnt_d     = CNT_W'(WIDTH);
              state_d   = MD_CALC;
              if (w_is_div) begin
                acc_d = {{WIDTH{1'b0}}, w_abs1};
                b_d   = w_abs2;
              end else begin
                acc_d = {{WIDTH{1'b0}}, w_abs2};
                b_d   = w_abs1;
              end
            end
          end
        end
        MD_CALC: begin
          if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
            if (!w_rem_sub[WIDTH])
              acc_d = {w_rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
              acc_d = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1))
            state_d = MD_FIX;
        end
        MD_FIX: begin
          if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
            hi_d = w_rem_fix;
            lo_d = w_quo_fix;
          end else begin
            {hi_d, lo_d} = w_prod_fix;
          end
          state_d = MD_DONE;
        end
        MD_DONE: begin
          if (result_ready)
            state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign start_ready  = (state_q == MD_IDLE);
  assign busy         = (state_q != MD_IDLE);
  assign result_valid = (state_q == MD_DONE);
  assign result_hi    = hi_q;
  assign result_lo    = lo_q;
  assign div_by_zero  = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Brief    : Directed-vector bench for ex_muldiv_unit at WIDTH=32 and WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] operand_1, operand_2;
  logic        result_valid, result_ready;
  logic [31:0] result_hi, result_lo;
  logic        div_by_zero, busy;

  logic        s8_start_valid, s8_start_ready;
  logic [1:0]  s8_op;
  logic [7:0]  s8_operand_1, s8_operand_2;
  logic        s8_result_valid, s8_result_ready;
  logic [7:0]  s8_result_hi, s8_result_lo;
  logic        s8_div_by_zero, s8_busy;

  int checks;
  int errors;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready), .op(op),
    .operand_1(operand_1), .operand_2(operand_2),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  ex_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .start_valid(s8_start_valid), .start_ready(s8_start_ready), .op(s8_op),
    .operand_1(s8_operand_1), .operand_2(s8_operand_2),
    .result_valid(s8_result_valid), .result_ready(s8_result_ready),
    .result_hi(s8_result_hi), .result_lo(s8_result_lo),
    .div_by_zero(s8_div_by_zero), .busy(s8_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency 1 = the cycle right after the accepting edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                        output int lat, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    op = o; operand_1 = a; operand_2 = b; start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!result_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!result_valid) to = 1'b1;
    hi = result_hi; lo = result_lo; dz = div_by_zero;
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({start_ready, result_valid, busy, div_by_zero} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000", {start_ready, result_valid, busy, div_by_zero});
    end
    checks++;
    if ({result_hi, result_lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", {result_hi, result_lo});
    end
  endtask

  task automatic test_multu();
    logic [31:0] hi, lo; logic dz; int lat; bit to;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, dz, lat, to);
    checks++;
    if (to || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max got %h want fffffffe00000001 (timeout %0d)", {hi, lo}, to);
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL multu_latency got %0d want 34", lat);
    end
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo; logic dz; int lat; bit to;
    run_op(MD_MULT, 32'hFFFF_FFF9, 32'd3, hi, lo, dz, lat, to);
    checks++;
    if (to || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg7x3 got %h want ffffffffffffffeb", {hi, lo});
    end
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, hi, lo, dz, lat, to);
    checks++;
    if (to || {hi, lo} !== 64'h4000_0000_0000_0000) begin
      errors++;
      $display("FAIL mult_minxmin got %h want 4000000000000000", {hi, lo});
    end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo; logic dz; int lat; bit to;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo, dz, lat, to);
    checks++;
    if (to || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg7by2 got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    checks++;
    if (lat !== 34 || dz !== 1'b0) begin
      errors++;
      $display("FAIL div_latency got lat=%0d dz=%b want lat=34 dz=0", lat, dz);
    end
    run_op(MD_DIVU, 32'd100, 32'd7, hi, lo, dz, lat, to);
    checks++;
    if (to || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL divu_100by7 got hi=%0d lo=%0d want hi=2 lo=14", hi, lo);
    end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, dz, lat, to);
    checks++;
    if (to || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow got hi=%h lo=%h want hi=0 lo=80000000", hi, lo);
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] hi, lo; logic dz; int lat; bit to;
    run_op(MD_DIVU, 32'd5, 32'd0, hi, lo, dz, lat, to);
    checks++;
    if (to || hi !== 32'd5 || lo !== 32'hFFFF_FFFF || dz !== 1'b1) begin
      errors++;
      $display("FAIL divu_by_zero got hi=%h lo=%h dz=%b want hi=5 lo=ffffffff dz=1", hi, lo, dz);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dbz_latency got %0d want 1", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo; logic dz; int lat; bit to; int n; bit bad;
    @(negedge clk);
    op = MD_MULTU; operand_1 = 32'd6; operand_2 = 32'd7; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    bad = !result_valid;
    for (int i = 0; i < 5; i++) begin
      if (!result_valid || start_ready !== 1'b0 || result_hi !== 32'd0 || result_lo !== 32'd42) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable got valid=%b sr=%b hi=%h lo=%h want valid=1 sr=0 hi=0 lo=2a",
               result_valid, start_ready, result_hi, result_lo);
    end
    result_ready = 1'b1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL handshake_cycle_start_ready got %b want 0", start_ready);
    end
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake got sr=%b valid=%b want sr=1 valid=0", start_ready, result_valid);
    end
    run_op(MD_DIVU, 32'd100, 32'd7, hi, lo, dz, lat, to);
    checks++;
    if (to || hi !== 32'd2 || lo !== 32'd14 || lat !== 34) begin
      errors++;
      $display("FAIL back_to_back got hi=%0d lo=%0d lat=%0d want hi=2 lo=14 lat=34", hi, lo, lat);
    end
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    op = MD_MULTU; operand_1 = 32'd9; operand_2 = 32'd9; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc got busy=%b sr=%b valid=%b want 0 1 0", busy, start_ready, result_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_result got valid=1 want 0");
    end
    @(negedge clk);
    flush = 1'b1; start_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; start_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo; logic dz; int lat; bit to; bit seen;
    @(negedge clk);
    op = MD_MULTU; operand_1 = 32'd11; operand_2 = 32'd13; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b sr=%b valid=%b want 0 1 0", busy, start_ready, result_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_result got valid=1 want 0");
    end
    run_op(MD_MULTU, 32'd3, 32'd4, hi, lo, dz, lat, to);
    checks++;
    if (to || hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL multu_after_abort got hi=%0d lo=%0d want hi=0 lo=12", hi, lo);
    end
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    s8_op = MD_MULTU; s8_operand_1 = 8'hFF; s8_operand_2 = 8'hFF; s8_start_valid = 1'b1;
    @(posedge clk);
    #1 s8_start_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s8_result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!s8_result_valid || s8_result_hi !== 8'hFE || s8_result_lo !== 8'h01) begin
      errors++;
      $display("FAIL w8_multu got valid=%b hi=%h lo=%h want 1 fe 01", s8_result_valid, s8_result_hi, s8_result_lo);
    end
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL w8_latency got %0d want 10", lat);
    end
    s8_result_ready = 1'b1;
    @(posedge clk);
    #1 s8_result_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; start_valid = 1'b0; op = 2'b00;
    operand_1 = '0; operand_2 = '0; result_ready = 1'b0;
    s8_start_valid = 1'b0; s8_op = 2'b00; s8_operand_1 = '0; s8_operand_2 = '0; s8_result_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
